// File: rtl/fft_wn_pkg.sv
// Shared types and Q1.14 quarter-wave cosine source for the twiddle sequencer.
// WN_COS_Q14 entries are produced by wn_cos_q14(m) at elaboration, m in 0..WN_TBL_Q.
package fft_wn_pkg;

   localparam int WN_TBL_LOG2 = 10;
   localparam int WN_TBL_Q    = 1 << (WN_TBL_LOG2 - 2);

   typedef enum logic {IDLE, RUN} wn_state_t;

   // round(cos(2*pi*m/1024) * 16384) via a Q28 fixed-point Taylor series
   function automatic int wn_cos_q14(input int m);
      longint s;
      longint x;
      longint term;
      longint sum;
      s    = longint'(1) <<< 28;
      x    = (longint'(843314857) * longint'(m)) / 512;
      term = s;
      sum  = s;
      for (int unsigned n = 1; n <= 10; n++) begin
         term = (term * x) / s;
         term = (term * x) / s;
         term = -term / longint'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return int'((sum * 16384 + (s >>> 1)) / s);
   endfunction

   function automatic int wn_q14_round(input int v, input int f);
      if (f >= 14) return v;
      return (v + (1 << (13 - f))) >>> (14 - f);
   endfunction

endpackage

// File: rtl/fft_wn_lane.sv
// Combinational k -> W_N^k for one lane: quarter-wave fold over a rounded magnitude ROM.
module fft_wn_lane
   import fft_wn_pkg::*;
#(
   parameter int FFT_LEN_LOG2 = 6,
   parameter int WN_WID       = 10
) (
   input  logic [FFT_LEN_LOG2-2:0] k_i,
   input  logic                    inv_i,
   output logic [WN_WID-1:0]       re_o,
   output logic [WN_WID-1:0]       im_o
);

   localparam int KW   = FFT_LEN_LOG2 - 1;
   localparam int Q    = 1 << (FFT_LEN_LOG2 - 2);
   localparam int STEP = 1 << (WN_TBL_LOG2 - FFT_LEN_LOG2);
   localparam int F    = WN_WID - 2;
   localparam logic [KW-1:0] Q_K = KW'(Q);

   logic [WN_WID-1:0] mag_tbl [0:Q];
   logic [KW-1:0]     idx_re;
   logic [KW-1:0]     idx_im;
   logic              neg_re;
   logic [WN_WID-1:0] mag_re;
   logic [WN_WID-1:0] mag_im;

   // rounding happens before any sign is applied, so +/- magnitudes stay symmetric
   for (genvar m = 0; m <= Q; m++) begin : g_tbl
      localparam int MAG = wn_q14_round(wn_cos_q14(m * STEP), F);
      assign mag_tbl[m] = WN_WID'(MAG);
   end

   always_comb begin
      idx_re = k_i;
      idx_im = Q_K - k_i;
      neg_re = 1'b0;
      if (k_i > Q_K) begin
         idx_re = '0 - k_i;
         idx_im = k_i - Q_K;
         neg_re = 1'b1;
      end
   end

   assign mag_re = mag_tbl[idx_re];
   assign mag_im = mag_tbl[idx_im];
   assign re_o   = neg_re ? -mag_re : mag_re;
   assign im_o   = inv_i ? mag_im : -mag_im;

endmodule

// File: rtl/fft_wn_seq.sv
// Sequenced radix-2 DIT twiddle source: streams N/2 factors of one stage, LANES per beat.
// Optional FFT_WN_INV_EN adds inv_i for conjugate (IFFT) twiddles.
module fft_wn_seq
   import fft_wn_pkg::*;
#(
   parameter int FFT_LEN_LOG2 = 6,
   parameter int LANES        = 16,
   parameter int WN_WID       = 10,
   parameter int STG_WID      = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      start_i,
   input  logic [STG_WID-1:0]        stage_i,
`ifdef FFT_WN_INV_EN
   input  logic                      inv_i,
`endif
   output logic                      busy_o,
   output logic                      err_o,
   output logic                      fft_wn_valid_o,
   input  logic                      fft_wn_ready_i,
   output logic                      fft_wn_last_o,
   output logic [FFT_LEN_LOG2-2:0]   fft_wn_beat_o,
   output logic [LANES*WN_WID-1:0]   fft_wn_re_o,
   output logic [LANES*WN_WID-1:0]   fft_wn_im_o
);

   localparam int KW    = FFT_LEN_LOG2 - 1;
   localparam int BEATS = (1 << KW) / LANES;
   localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);

   wn_state_t          state_q;
   logic [STG_WID-1:0] stage_q;
   logic               inv_q;
   logic               inv_in;
   logic               xfer;
   logic               can_start;
   logic               stage_ok;
   logic               go;
   logic [STG_WID-1:0] sel_stage;
   logic [KW-1:0]      sel_beat;
   logic               sel_inv;
   int unsigned        j;
   int unsigned        s;
   logic [KW-1:0]      lane_k  [LANES];
   logic [WN_WID-1:0]  lane_re [LANES];
   logic [WN_WID-1:0]  lane_im [LANES];
   logic [LANES*WN_WID-1:0] nxt_re;
   logic [LANES*WN_WID-1:0] nxt_im;

`ifdef FFT_WN_INV_EN
   assign inv_in = inv_i;
`else
   assign inv_in = 1'b0;
`endif

   // a start landing on the final handshake is taken, so sequences chain without a bubble
   assign xfer      = fft_wn_valid_o & fft_wn_ready_i;
   assign can_start = (state_q == IDLE) | (xfer & fft_wn_last_o);
   assign stage_ok  = stage_i < STG_WID'(FFT_LEN_LOG2);
   assign go        = can_start & start_i & stage_ok;
   assign sel_stage = go ? stage_i : stage_q;
   assign sel_beat  = go ? '0 : fft_wn_beat_o + KW'(1);
   assign sel_inv   = go ? inv_in : inv_q;

   // k = (j mod 2^s) << (log2(N/2) - s), j = beat*LANES + lane
   always_comb begin
      j = '0;
      s = 32'(sel_stage);
      for (int unsigned l = 0; l < LANES; l++) begin
         j         = 32'(sel_beat) * 32'(LANES) + l;
         lane_k[l] = KW'((j & ((32'd1 << s) - 32'd1)) << (KW - s));
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fft_wn_lane #(
         .FFT_LEN_LOG2 (FFT_LEN_LOG2),
         .WN_WID       (WN_WID)
      ) u_lane (
         .k_i   (lane_k[l]),
         .inv_i (sel_inv),
         .re_o  (lane_re[l]),
         .im_o  (lane_im[l])
      );
   end

   always_comb begin
      nxt_re = '0;
      nxt_im = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         nxt_re[l*WN_WID +: WN_WID] = lane_re[l];
         nxt_im[l*WN_WID +: WN_WID] = lane_im[l];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         stage_q        <= '0;
         inv_q          <= 1'b0;
         busy_o         <= 1'b0;
         err_o          <= 1'b0;
         fft_wn_valid_o <= 1'b0;
         fft_wn_last_o  <= 1'b0;
         fft_wn_beat_o  <= '0;
         fft_wn_re_o    <= '0;
         fft_wn_im_o    <= '0;
      end else begin
         err_o <= can_start & start_i & ~stage_ok;
         if (go) begin
            state_q        <= RUN;
            stage_q        <= stage_i;
            inv_q          <= inv_in;
            busy_o         <= 1'b1;
            fft_wn_valid_o <= 1'b1;
            fft_wn_last_o  <= (BEATS == 1);
            fft_wn_beat_o  <= '0;
            fft_wn_re_o    <= nxt_re;
            fft_wn_im_o    <= nxt_im;
         end else if (xfer) begin
            if (fft_wn_last_o) begin
               state_q        <= IDLE;
               busy_o         <= 1'b0;
               fft_wn_valid_o <= 1'b0;
               fft_wn_last_o  <= 1'b0;
            end else begin
               fft_wn_beat_o  <= sel_beat;
               fft_wn_last_o  <= (sel_beat == LAST_BEAT);
               fft_wn_re_o    <= nxt_re;
               fft_wn_im_o    <= nxt_im;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_wn_seq.sv
// Directed self-checking bench for fft_wn_seq at N=64, LANES=16, WN_WID=10.
module tb_fft_wn_seq;

   localparam int LOG2  = 6;
   localparam int LANES = 16;
   localparam int W     = 10;
   localparam int SW    = 4;

   // round(cos(2*pi*m/64) * 256), m = 0..16
   localparam int C64 [0:16] = '{256, 255, 251, 245, 237, 226, 213, 198, 181,
                                 162, 142, 121, 98, 74, 50, 25, 0};

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [SW-1:0]     stage;
`ifdef FFT_WN_INV_EN
   logic              inv;
`endif
   logic              busy;
   logic              err;
   logic              valid;
   logic              ready;
   logic              last;
   logic [LOG2-2:0]   beat;
   logic [LANES*W-1:0] re;
   logic [LANES*W-1:0] im;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fft_wn_seq #(
      .FFT_LEN_LOG2 (LOG2),
      .LANES        (LANES),
      .WN_WID       (W),
      .STG_WID      (SW)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .start_i        (start),
      .stage_i        (stage),
`ifdef FFT_WN_INV_EN
      .inv_i          (inv),
`endif
      .busy_o         (busy),
      .err_o          (err),
      .fft_wn_valid_o (valid),
      .fft_wn_ready_i (ready),
      .fft_wn_last_o  (last),
      .fft_wn_beat_o  (beat),
      .fft_wn_re_o    (re),
      .fft_wn_im_o    (im)
   );

   function automatic int get_re(input int l);
      logic signed [W-1:0] v;
      v = re[l*W +: W];
      return int'(v);
   endfunction

   function automatic int get_im(input int l);
      logic signed [W-1:0] v;
      v = im[l*W +: W];
      return int'(v);
   endfunction

   function automatic void exp_tw(input int s, input int b, input int l, input bit cj,
                                  output int er, output int ei);
      int jj;
      int k;
      jj = b * LANES + l;
      k  = (jj % (1 << s)) * (64 >> (s + 1));
      if (k <= 16) begin
         er = C64[k];
         ei = -C64[16 - k];
      end else begin
         er = -C64[32 - k];
         ei = -C64[k - 16];
      end
      if (cj) ei = -ei;
   endfunction

   task automatic do_start(input int s);
      start = 1'b1;
      stage = SW'(s);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      ready = 1'b1;
      for (int i = 0; i < 16 && valid; i++) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: valid=%b busy=%b expected 0 0", name, valid, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      stage = '0;
      ready = 1'b0;
`ifdef FFT_WN_INV_EN
      inv = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, err, valid, last} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/err/valid/last=%b expected 0000", {busy, err, valid, last});
      end
      checks++;
      if (beat !== '0 || re !== '0 || im !== '0) begin
         errors++;
         $display("FAIL reset_data: beat=%0d re=%h im=%h expected all 0", beat, re, im);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: valid=%b busy=%b expected 0 0", valid, busy);
      end
   endtask

   task automatic test_stage0();
      ready = 1'b1;
      do_start(0);
      checks++;
      if ({valid, busy, last} !== 3'b110 || beat !== 5'd0) begin
         errors++;
         $display("FAIL s0_beat0_ctrl: valid/busy/last=%b beat=%0d expected 110 0", {valid, busy, last}, beat);
      end
      for (int l = 0; l < LANES; l++) begin
         checks++;
         if (get_re(l) !== 256 || get_im(l) !== 0) begin
            errors++;
            $display("FAIL s0_b0_lane%0d: re=%0d im=%0d expected 256 0", l, get_re(l), get_im(l));
         end
      end
      @(negedge clk);
      checks++;
      if ({valid, last} !== 2'b11 || beat !== 5'd1) begin
         errors++;
         $display("FAIL s0_beat1_ctrl: valid/last=%b beat=%0d expected 11 1", {valid, last}, beat);
      end
      for (int l = 0; l < LANES; l++) begin
         checks++;
         if (get_re(l) !== 256 || get_im(l) !== 0) begin
            errors++;
            $display("FAIL s0_b1_lane%0d: re=%0d im=%0d expected 256 0", l, get_re(l), get_im(l));
         end
      end
      @(negedge clk);
      checks++;
      if ({valid, busy, last} !== 3'b000) begin
         errors++;
         $display("FAIL s0_end: valid/busy/last=%b expected 000", {valid, busy, last});
      end
   endtask

   task automatic test_stage1();
      logic [W-1:0] raw;
      ready = 1'b0;
      do_start(1);
      for (int l = 0; l < LANES; l++) begin
         checks++;
         if ((l % 2 == 0 && (get_re(l) !== 256 || get_im(l) !== 0)) ||
             (l % 2 == 1 && (get_re(l) !== 0 || get_im(l) !== -256))) begin
            errors++;
            $display("FAIL s1_lane%0d: re=%0d im=%0d expected %0d %0d", l, get_re(l), get_im(l),
                     (l % 2 == 0) ? 256 : 0, (l % 2 == 0) ? 0 : -256);
         end
      end
      raw = im[W +: W];
      checks++;
      if (raw !== 10'h300) begin
         errors++;
         $display("FAIL s1_lane1_raw: im=%h expected 300", raw);
      end
      drain("s1");
   endtask

   task automatic test_stage4();
      int er;
      int ei;
      ready = 1'b0;
      do_start(4);
      checks++;
      if (get_re(1) !== 251 || get_im(1) !== -50) begin
         errors++;
         $display("FAIL s4_lane1: re=%0d im=%0d expected 251 -50", get_re(1), get_im(1));
      end
      checks++;
      if (get_re(4) !== 181 || get_im(4) !== -181) begin
         errors++;
         $display("FAIL s4_lane4: re=%0d im=%0d expected 181 -181", get_re(4), get_im(4));
      end
      checks++;
      if (get_re(8) !== 0 || get_im(8) !== -256) begin
         errors++;
         $display("FAIL s4_lane8: re=%0d im=%0d expected 0 -256", get_re(8), get_im(8));
      end
      checks++;
      if (get_re(15) !== -251 || get_im(15) !== -50) begin
         errors++;
         $display("FAIL s4_lane15: re=%0d im=%0d expected -251 -50", get_re(15), get_im(15));
      end
      for (int b = 0; b < 2; b++) begin
         for (int l = 0; l < LANES; l++) begin
            exp_tw(4, b, l, 1'b0, er, ei);
            checks++;
            if (get_re(l) !== er || get_im(l) !== ei) begin
               errors++;
               $display("FAIL s4_b%0d_lane%0d: re=%0d im=%0d expected %0d %0d", b, l,
                        get_re(l), get_im(l), er, ei);
            end
         end
         ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
      end
      drain("s4");
   endtask

   task automatic test_stall();
      logic [LANES*W-1:0] re_s;
      logic [LANES*W-1:0] im_s;
      logic [LOG2-2:0]    beat_s;
      ready = 1'b1;
      do_start(5);
      checks++;
      if (valid !== 1'b1 || beat !== 5'd0 || get_re(0) !== 256 || get_im(0) !== 0) begin
         errors++;
         $display("FAIL s5_beat0: valid=%b beat=%0d re0=%0d im0=%0d expected 1 0 256 0",
                  valid, beat, get_re(0), get_im(0));
      end
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if (beat !== 5'd1 || last !== 1'b1 || get_re(0) !== 0 || get_im(0) !== -256) begin
         errors++;
         $display("FAIL s5_b1_lane0: beat=%0d last=%b re=%0d im=%0d expected 1 1 0 -256",
                  beat, last, get_re(0), get_im(0));
      end
      checks++;
      if (get_re(15) !== -255 || get_im(15) !== -25) begin
         errors++;
         $display("FAIL s5_b1_lane15: re=%0d im=%0d expected -255 -25", get_re(15), get_im(15));
      end
      re_s   = re;
      im_s   = im;
      beat_s = beat;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (valid !== 1'b1 || last !== 1'b1 || beat !== beat_s || re !== re_s || im !== im_s) begin
            errors++;
            $display("FAIL s5_stall%0d: valid=%b last=%b beat=%0d expected 1 1 %0d with data held",
                     c, valid, last, beat, beat_s);
         end
      end
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL s5_release: valid=%b busy=%b expected 0 0", valid, busy);
      end
   endtask

   task automatic test_err();
      ready = 1'b1;
      start = 1'b1;
      stage = SW'(6);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({err, valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL err_pulse: err/valid/busy=%b expected 100", {err, valid, busy});
      end
      @(negedge clk);
      checks++;
      if ({err, valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL err_clear: err/valid/busy=%b expected 000", {err, valid, busy});
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      ready = 1'b0;
      do_start(4);
      start = 1'b1;
      stage = SW'(0);
      @(negedge clk);
      stage = SW'(6);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b0 || beat !== 5'd0 || get_re(1) !== 251 || get_im(1) !== -50) begin
         errors++;
         $display("FAIL busy_ignore: err=%b beat=%0d re1=%0d im1=%0d expected 0 0 251 -50",
                  err, beat, get_re(1), get_im(1));
      end
      ready = 1'b1;
      n = 0;
      for (int i = 0; i < 16 && valid; i++) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 2 || valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_beats: handshakes=%0d valid=%b expected 2 0", n, valid);
      end
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      do_start(0);
      @(negedge clk);
      start = 1'b1;
      stage = SW'(4);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({valid, busy, last} !== 3'b110 || beat !== 5'd0 || get_re(1) !== 251 || get_im(1) !== -50) begin
         errors++;
         $display("FAIL b2b: valid/busy/last=%b beat=%0d re1=%0d im1=%0d expected 110 0 251 -50",
                  {valid, busy, last}, beat, get_re(1), get_im(1));
      end
      drain("b2b");
   endtask

   task automatic test_async_reset();
      ready = 1'b0;
      do_start(4);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, err, valid, last} !== 4'b0000 || beat !== '0 || re !== '0 || im !== '0) begin
         errors++;
         $display("FAIL async_rst: busy/err/valid/last=%b beat=%0d re=%h im=%h expected all 0",
                  {busy, err, valid, last}, beat, re, im);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_start(0);
      checks++;
      if (valid !== 1'b1 || beat !== 5'd0 || get_re(3) !== 256 || get_im(3) !== 0) begin
         errors++;
         $display("FAIL rst_restart: valid=%b beat=%0d re3=%0d im3=%0d expected 1 0 256 0",
                  valid, beat, get_re(3), get_im(3));
      end
      drain("rst");
   endtask

`ifdef FFT_WN_INV_EN
   task automatic test_inv();
      ready = 1'b0;
      inv   = 1'b1;
      do_start(4);
      inv   = 1'b0;
      checks++;
      if (get_re(1) !== 251 || get_im(1) !== 50) begin
         errors++;
         $display("FAIL inv_lane1: re=%0d im=%0d expected 251 50", get_re(1), get_im(1));
      end
      checks++;
      if (get_re(15) !== -251 || get_im(15) !== 50) begin
         errors++;
         $display("FAIL inv_lane15: re=%0d im=%0d expected -251 50", get_re(15), get_im(15));
      end
      drain("inv");
   endtask
`endif

   initial begin
      test_reset();
      test_stage0();
      test_stage1();
      test_stage4();
      test_stall();
      test_err();
      test_busy_ignore();
      test_back_to_back();
      test_async_reset();
`ifdef FFT_WN_INV_EN
      test_inv();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
